// File: rtl/pix_stream_gen_pkg.sv
// Shared types and constants for the pixel stream generator: FSM states, pattern
// mode encodings and the pattern LFSR.
package pix_stream_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    LINE = 3'd2,
    HBL  = 3'd3,
    VBL  = 3'd4
  } state_e;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_CONST = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  // Taps of x^8+x^6+x^5+x^4+1 for a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_POLY)};
  endfunction

  function automatic logic [7:0] lfsr_step4(input logic [7:0] s);
    return lfsr_step(lfsr_step(lfsr_step(lfsr_step(s))));
  endfunction

endpackage

// File: rtl/pix_stream_gen_pattern.sv
// Pattern generator: one 32-bit pixel dword per enabled cycle, registered output.
// Byte 0 is the leftmost pixel; the output is zero whenever en is low.
module pix_pattern
  import pix_stream_gen_pkg::*;
(
  input  logic        c,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  input  logic [8:0]  x,
  input  logic [9:0]  y,
  input  logic [7:0]  lfsr,
  input  logic        stamp_en,
  input  logic [15:0] stamp,
  output logic [31:0] p
);

  logic [31:0] pat_s;
  logic [7:0]  lf_s;
  logic [31:0] p_d;
  logic [31:0] p_q;

  // Byte-wise pattern for dword (x, y); the LFSR walks one step per byte.
  always_comb begin
    lf_s  = lfsr;
    pat_s = 32'h0;
    for (int k = 0; k < 4; k++) begin
      case (mode)
        PAT_RAMP:  pat_s[8*k +: 8] = 8'({x, 2'b00}) + 8'(k) + 8'(y) + seed;
        PAT_CHECK: pat_s[8*k +: 8] = (x[0] ^ y[0]) ? seed : ~seed;
        PAT_CONST: pat_s[8*k +: 8] = seed;
        PAT_LFSR: begin
          pat_s[8*k +: 8] = lf_s;
          lf_s            = lfsr_step(lf_s);
        end
        default:   pat_s[8*k +: 8] = 8'h00;
      endcase
    end
    if (!en) begin
      p_d = 32'h0;
    end else if (stamp_en) begin
      p_d = {pat_s[31:16], stamp};
    end else begin
      p_d = pat_s;
    end
  end

  // Output register absorbing the pattern latency.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      p_q <= 32'h0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/pix_stream_gen.sv
// Frame/line timing FSM of the test-pattern stream generator (fv, lv, p).
// Define PIX_STREAM_GEN_FRAME_STAMP_EN to stamp a 16-bit frame count into p[15:0] of dword (0,0).
module pix_stream_gen
  import pix_stream_gen_pkg::*;
#(
  parameter int COLS_DW = 8,
  parameter int ROWS    = 8,
  parameter int HBLANK  = 4,
  parameter int VLEAD   = 2,
  parameter int VBLANK  = 16
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  output logic [31:0] p,
  output logic        lv,
  output logic        fv,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [8:0]  COLS_LAST   = 9'(COLS_DW - 1);
  localparam logic [9:0]  ROWS_LAST   = 10'(ROWS - 1);
  localparam logic [15:0] VLEAD_LAST  = 16'(VLEAD - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(HBLANK - 1);
  localparam logic [15:0] VBLANK_LAST = 16'(VBLANK - 1);

  state_e      state_d, state_q;
  logic [15:0] cnt_d, cnt_q;
  logic [8:0]  col_d, col_q;
  logic [9:0]  row_d, row_q;
  logic        cont_d, cont_q;
  logic        stop_seen_d, stop_seen_q;
  logic [1:0]  mode_d, mode_q;
  logic [7:0]  seed_d, seed_q;
  logic [7:0]  lfsr_d, lfsr_q;
  logic        lv_d, lv_q;
  logic        fv_d, fv_q;
  logic        busy_d, busy_q;
  logic        frame_done_d, frame_done_q;
  logic        stamp_en_s;
  logic [15:0] stamp_s;

  // Next-state, counter and latch logic; col_d/row_d double as the early pattern address.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    cont_d       = cont_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    lfsr_d       = lfsr_q;
    frame_done_d = 1'b0;
    stop_seen_d  = (state_q == IDLE) ? 1'b0 : (stop_seen_q | stop);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD;
          cont_d  = continuous;
        end else begin
          state_d = IDLE;
        end
      end
      LEAD: begin
        if (cnt_q == VLEAD_LAST) begin
          state_d = LINE;
          cnt_d   = 16'd0;
          col_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LINE: begin
        if (col_q == COLS_LAST) begin
          state_d = HBL;
          cnt_d   = 16'd0;
        end else begin
          col_d = col_q + 9'd1;
        end
      end
      HBL: begin
        if (cnt_q == HBLANK_LAST) begin
          cnt_d = 16'd0;
          if (row_q == ROWS_LAST) begin
            state_d      = VBL;
            frame_done_d = 1'b1;
          end else begin
            state_d = LINE;
            row_d   = row_q + 10'd1;
            col_d   = 9'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      VBL: begin
        if (cnt_q == VBLANK_LAST) begin
          cnt_d   = 16'd0;
          state_d = (cont_q && !(stop_seen_q || stop)) ? LEAD : IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: sample pattern controls, reseed the LFSR, clear the counters.
    if (state_d == LEAD && state_q != LEAD) begin
      mode_d = mode;
      seed_d = seed;
      lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
      cnt_d  = 16'd0;
      col_d  = 9'd0;
      row_d  = 10'd0;
    end else if (state_d == LINE) begin
      lfsr_d = lfsr_step4(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end

    lv_d   = (state_d == LINE);
    fv_d   = (state_d == LEAD) || (state_d == LINE) || (state_d == HBL);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      col_q        <= 9'd0;
      row_q        <= 10'd0;
      cont_q       <= 1'b0;
      stop_seen_q  <= 1'b0;
      mode_q       <= 2'd0;
      seed_q       <= 8'h00;
      lfsr_q       <= 8'h01;
      lv_q         <= 1'b0;
      fv_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cont_q       <= cont_d;
      stop_seen_q  <= stop_seen_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      lfsr_q       <= lfsr_d;
      lv_q         <= lv_d;
      fv_q         <= fv_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIX_STREAM_GEN_FRAME_STAMP_EN
  logic [15:0] frame_cnt_d, frame_cnt_q;

  // Completed-frame counter.
  always_comb begin
    if (frame_done_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign stamp_en_s = (col_d == 9'd0) && (row_d == 10'd0);
  assign stamp_s    = frame_cnt_q;
`else
  assign stamp_en_s = 1'b0;
  assign stamp_s    = 16'h0;
`endif

  pix_pattern u_pattern (
    .c        (c),
    .rst_n    (rst_n),
    .en       (lv_d),
    .mode     (mode_q),
    .seed     (seed_q),
    .x        (col_d),
    .y        (row_d),
    .lfsr     (lfsr_q),
    .stamp_en (stamp_en_s),
    .stamp    (stamp_s),
    .p        (p)
  );

  assign lv         = lv_q;
  assign fv         = fv_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pix_stream_gen.sv
// Self-checking bench for pix_stream_gen: frame-level reference model compared every
// cycle, plus literal expectations for ramp, checker, LFSR, stop, reset and mode timing.
module tb_pix_stream_gen;

  localparam int COLS  = 2;
  localparam int NROWS = 4;
  localparam int HB    = 4;
  localparam int VL    = 2;
  localparam int VB    = 6;
  localparam int FLEN  = VL + NROWS * (COLS + HB) + VB;
`ifdef PIX_STREAM_GEN_FRAME_STAMP_EN
  localparam logic [31:0] M00 = 32'hFFFF0000;
`else
  localparam logic [31:0] M00 = 32'hFFFFFFFF;
`endif

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  seed = 8'h00;
  logic [31:0] p;
  logic        lv, fv, busy, frame_done;

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic        busy;
    logic        fd;
    logic [31:0] p;
  } exp_t;

  exp_t q[$];
  exp_t exp_v = '0;
  bit   in_seq = 1'b0;
  bit   cont_l = 1'b0;
  bit   stop_seen = 1'b0;
  int   frames = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fd_total = 0;

  pix_stream_gen #(
    .COLS_DW (COLS),
    .ROWS    (NROWS),
    .HBLANK  (HB),
    .VLEAD   (VL),
    .VBLANK  (VB)
  ) dut (
    .c          (c),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .mode       (mode),
    .seed       (seed),
    .p          (p),
    .lv         (lv),
    .fv         (fv),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 c = ~c;

  function automatic exp_t mk(input logic f, input logic l, input logic b, input logic d,
                              input logic [31:0] px);
    exp_t e;
    e.fv = f; e.lv = l; e.busy = b; e.fd = d; e.p = px;
    return e;
  endfunction

  function automatic logic [7:0] lf_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Whole-frame expected output sequence, one entry per clock cycle.
  function automatic void gen_frame(input logic [1:0] m, input logic [7:0] s);
    logic [7:0]  lf;
    logic [7:0]  b;
    logic [31:0] d;
    lf = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < VL; i++) q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
    for (int y = 0; y < NROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        for (int k = 0; k < 4; k++) begin
          case (m)
            2'd0:    b = 8'((4 * x + k + y + int'(s)) % 256);
            2'd1:    b = (((x ^ y) & 1) != 0) ? s : ~s;
            2'd2:    b = s;
            default: begin b = lf; lf = lf_next(lf); end
          endcase
          d[8*k +: 8] = b;
        end
`ifdef PIX_STREAM_GEN_FRAME_STAMP_EN
        if (x == 0 && y == 0) d[15:0] = 16'(frames);
`endif
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, d));
      end
      for (int i = 0; i < HB; i++) q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
    end
    for (int i = 0; i < VB; i++) q.push_back(mk(1'b0, 1'b0, 1'b1, (i == 0), 32'h0));
  endfunction

  always @(posedge c) begin
    if (!rst_n) begin
      q.delete();
      in_seq = 1'b0;
      frames = 0;
      exp_v  = '0;
    end else begin
      if (in_seq) stop_seen = stop_seen | stop;
      if (q.size() == 0) begin
        if (in_seq) begin
          if (cont_l && !stop_seen) gen_frame(mode, seed);
          else in_seq = 1'b0;
        end else if (start) begin
          in_seq    = 1'b1;
          cont_l    = continuous;
          stop_seen = 1'b0;
          gen_frame(mode, seed);
        end
      end
      if (q.size() > 0) begin
        exp_v = q.pop_front();
        if (exp_v.fd) frames++;
      end else begin
        exp_v = '0;
      end
    end
  end

  always @(negedge c) begin
    n_tests++;
    if ({fv, lv, busy, frame_done, p} !== exp_v) begin
      n_fail++;
      $display("FAIL stream @%0t: got fv=%b lv=%b busy=%b fd=%b p=%h, expected fv=%b lv=%b busy=%b fd=%b p=%h",
               $time, fv, lv, busy, frame_done, p, exp_v.fv, exp_v.lv, exp_v.busy, exp_v.fd, exp_v.p);
    end
    if (frame_done === 1'b1) fd_total++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge c);
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  int  base;
  int  nl;
  bit  lvp;
  bit  saw;

  initial begin
    repeat (3) @(negedge c);
    rst_n = 1'b1;
    chk("reset_outputs", {28'd0, fv, lv, busy, frame_done}, 32'd0);

    // Ramp frame with exact cycle positions.
    @(negedge c); start = 1'b1; mode = 2'd0; seed = 8'h00; continuous = 1'b0;
    base = fd_total;
    for (int e = 0; e <= FLEN; e++) begin
      @(negedge c); start = 1'b0;
      case (e)
        0:         chk("fv_rise", {30'd0, fv, lv}, 32'h2);
        2:         chk("ramp_00", p & M00, 32'h03020100 & M00);
        3:         chk("ramp_10", p, 32'h07060504);
        4:         chk("hbl_p_zero", {31'd0, lv} | p, 32'h0);
        8:         chk("ramp_01", p, 32'h04030201);
        9:         chk("ramp_11", p, 32'h08070605);
        FLEN - VB: chk("fd_pulse", {30'd0, fv, frame_done}, 32'h1);
        FLEN - 1:  chk("busy_in_vbl", {31'd0, busy}, 32'h1);
        FLEN:      chk("busy_fall", {31'd0, busy}, 32'h0);
        default:   ;
      endcase
    end
    chk("fd_once", 32'(fd_total - base), 32'd1);

    // Checkerboard with seed AA.
    @(negedge c); start = 1'b1; mode = 2'd1; seed = 8'hAA;
    for (int e = 0; e <= FLEN; e++) begin
      @(negedge c); start = 1'b0;
      case (e)
        2:       chk("check_00", p & M00, 32'h55555555 & M00);
        3:       chk("check_10", p, 32'hAAAAAAAA);
        8:       chk("check_01", p, 32'hAAAAAAAA);
        9:       chk("check_11", p, 32'h55555555);
        default: ;
      endcase
    end

    // Continuous LFSR frames, stop during the second frame.
    base = fd_total;
    @(negedge c); start = 1'b1; continuous = 1'b1; mode = 2'd3; seed = 8'h00;
    @(negedge c); start = 1'b0; continuous = 1'b0;
    for (int n = 0; n < 20 && lv !== 1'b1; n++) @(negedge c);
    chk("lfsr_00", p & M00, 32'h08040201 & M00);
    @(negedge c);
    chk("lfsr_10", p, 32'h8E472311);
    for (int n = 0; n < 100 && fd_total == base; n++) @(negedge c);
    repeat (12) @(negedge c);
    stop = 1'b1;
    @(negedge c); stop = 1'b0;
    wait_idle("cont_stop_idle", 100);
    chk("cont_fd_count", 32'(fd_total - base), 32'd2);
    saw = 1'b0;
    repeat (40) begin
      @(negedge c);
      if (fv === 1'b1) saw = 1'b1;
    end
    chk("no_third_fv", {31'd0, saw}, 32'd0);

    // Start while busy and a mid-frame mode change are both deferred.
    @(negedge c); start = 1'b1; mode = 2'd0; seed = 8'h10;
    @(negedge c); start = 1'b0;
    repeat (8) @(negedge c);
    mode = 2'd2; seed = 8'h5C; start = 1'b1;
    @(negedge c); start = 1'b0;
    chk("start_while_busy", {31'd0, busy}, 32'd1);
    wait_idle("mode_frame_end", 100);
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    for (int n = 0; n < 20 && lv !== 1'b1; n++) @(negedge c);
    chk("new_mode_first", p & M00, 32'h5C5C5C5C & M00);
    wait_idle("mode2_end", 100);

    // Reset during row 3 aborts without frame_done.
    base = fd_total;
    @(negedge c); start = 1'b1; mode = 2'd0; seed = 8'h33;
    nl = 0; lvp = 1'b0;
    for (int n = 0; n < 200 && nl < 4; n++) begin
      @(negedge c); start = 1'b0;
      if (lv === 1'b1 && !lvp) nl++;
      lvp = (lv === 1'b1);
    end
    chk("row3_reached", 32'(nl), 32'd4);
    rst_n = 1'b0;
    @(negedge c); rst_n = 1'b1;
    chk("rst_abort", {28'd0, fv, lv, busy, frame_done}, 32'd0);
    chk("rst_p_zero", p, 32'h0);
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    wait_idle("after_rst_frame", 100);
    chk("after_rst_fd", 32'(fd_total - base), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge c);
      rst_n      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 5) == 0);
      continuous = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 19) == 0);
      mode       = 2'($urandom_range(0, 3));
      seed       = 8'($urandom);
    end
    @(negedge c); rst_n = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b1;
    wait_idle("drain", 200);
    stop = 1'b0;
    repeat (2) @(negedge c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
